fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the memory's combinational `pc` address, and captures the returned 40-bit word into a one-entry instruction register. That register is presented to the decode stage under a valid/ready handshake. Supports jump redirect with flush, HALT-opcode detection, restart, and a count of instructions handed over.

## Interface
Parameters:
- INSTRUCTION_WIDTH, 40, instruction word width (matches memory)
- PC_WIDTH, 5, program counter width (matches memory)
- OPCODE_WIDTH, 8, opcode field = instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]
- RESET_PC, 0, PC value after reset
- HALT_OPCODE, 8'hFF, opcode that stops fetching

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- en  in  1  run enable; low stalls new fetches
- pc  out  PC_WIDTH  address to instruction memory
- instruction  in  INSTRUCTION_WIDTH  memory read data (combinational from pc)
- ir  out  INSTRUCTION_WIDTH  held instruction to decode
- ir_pc  out  PC_WIDTH  address ir was fetched from
- ir_valid  out  1  ir holds an instruction
- ir_ready  in  1  decode accepts ir this cycle
- jump_valid  in  1  redirect request
- jump_target  in  PC_WIDTH  redirect address
- restart  in  1  leave HALT and resume fetching
- halted  out  1  FSM in HALT
- fetch_count  out  16  instructions handed over (ir_valid & ir_ready), saturates at 16'hFFFF

## Operation
- FSM states: IDLE, FETCH, HALT. IDLE→FETCH when en=1. FETCH→HALT when the word being loaded has opcode == HALT_OPCODE. HALT→FETCH when restart=1. No other transitions.
- Load condition (FETCH only): en=1 and (ir_valid=0 or ir_ready=1) and jump_valid=0. On load: ir←instruction, ir_pc←pc, ir_valid←1, pc←pc+1 modulo 2^PC_WIDTH (31→0 with default width).
- Handshake: transfer when ir_valid & ir_ready. After a transfer with no load, ir_valid←0. ir/ir_pc stay stable while ir_valid=1 and ir_ready=0.
- Jump (any state, highest priority): pc←jump_target, ir_valid←0, no load that cycle, state unchanged. A transfer in the same cycle still counts in fetch_count.
- HALT: the HALT instruction itself is loaded and presented; pc is incremented past it. No further loads; ir drains via the handshake. restart resumes at current pc. restart in IDLE/FETCH is ignored.
- en=0 in FETCH: no loads, ir still drains, state stays FETCH.
- halted = (state == HALT), registered.

## Timing
- Reset values: pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state IDLE. Reset mid-operation discards ir contents immediately (asynchronous).
- Memory read is combinational. The word at pc is captured on the same edge that advances pc.
- First instruction: en sampled high at edge N (IDLE→FETCH); ir_valid=1 with mem[RESET_PC] after edge N+1.
- Throughput: one instruction per cycle with ir_ready held high.
- Jump at edge J: ir_valid=0 after J; mem[jump_target] is in ir after J+1 (one-cycle bubble).
- HALT word loaded at edge H: halted=1 after H. restart at edge R: halted=0 after R; next load at R+1.

## Structure
- Package fetch_pkg: state enum {IDLE, FETCH, HALT}, OPCODE_WIDTH, HALT_OPCODE default, fetch_count width constant 16.
- Single module, no sub-modules. The instruction memory is instantiated alongside at the top level and is not inside this block.

## Test plan
- Reset, en=1, ir_ready=1, memory 0..4 = distinct words → ir sequence mem[0..4] on consecutive cycles, ir_pc 0..4, fetch_count=5.
- ir_ready=0 for 3 cycles with ir_valid=1 → ir/ir_pc stable, pc not advanced, fetch_count unchanged; ready high → streaming resumes with no duplicate or skip.
- jump_valid with target 5'd20 while streaming at pc=7 → ir_valid=0 for one cycle, then ir=mem[20], ir_pc=20, mem[7] never presented.
- pc at 31 with default PC_WIDTH → after load, pc=0; next ir_pc=0.
- mem[3] opcode 8'hFF → mem[3] presented, halted=1, no load of mem[4]; restart → ir=mem[4] next load.
- Async rst asserted mid-stream with ir_valid=1 → all outputs return to reset values without a clock edge; fetch_count saturation forced at 16'hFFFF stays at 16'hFFFF on further transfers.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam int             FETCH_OPCODE_WIDTH = 8;
    localparam logic [7:0]     FETCH_HALT_OPCODE  = 8'hFF;
    localparam int             FETCH_COUNT_WIDTH  = 16;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, one-entry instruction register and fetch sequencer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      INSTRUCTION_WIDTH = 40,
    parameter int                      PC_WIDTH          = 5,
    parameter int                      OPCODE_WIDTH      = FETCH_OPCODE_WIDTH,
    parameter logic [PC_WIDTH-1:0]     RESET_PC          = '0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = FETCH_HALT_OPCODE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [INSTRUCTION_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]          ir_pc,
    output logic                         ir_valid,
    input  logic                         ir_ready,
    input  logic                         jump_valid,
    input  logic [PC_WIDTH-1:0]          jump_target,
    input  logic                         restart,
    output logic                         halted,
    output logic [FETCH_COUNT_WIDTH-1:0] fetch_count
);

    fetch_state_t                   r_state;
    logic [PC_WIDTH-1:0]            r_pc;
    logic [INSTRUCTION_WIDTH-1:0]   r_ir;
    logic [PC_WIDTH-1:0]            r_ir_pc;
    logic                           r_ir_valid;
    logic                           r_halted;
    logic [FETCH_COUNT_WIDTH-1:0]   r_fetch_count;

    logic                           w_transfer;
    logic                           w_load;
    logic                           w_is_halt;
    logic [PC_WIDTH-1:0]            w_pc_inc;

    // A word is handed to decode whenever the register is full and decode is ready
    assign w_transfer = r_ir_valid & ir_ready;

    // Capture the memory word only when running, enabled, the register is free
    // (or being emptied this cycle) and no redirect is pending
    assign w_load     = (r_state == FETCH) & en & (~r_ir_valid | ir_ready) & ~jump_valid;

    assign w_is_halt  = (instruction[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

    // Natural wrap of the address counter gives the modulo increment
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);

    // Sequencer, program counter and instruction register; a jump overrides everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else if (jump_valid) begin
            r_pc       <= jump_target;
            r_ir_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_ir       <= instruction;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
                r_pc       <= w_pc_inc;
            end else if (w_transfer) begin
                r_ir_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // The HALT word itself is still presented; fetching stops after it
                    if (w_load && w_is_halt) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (restart) begin
                        r_state  <= FETCH;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of words accepted by decode, including on jump cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_transfer && (r_fetch_count != {FETCH_COUNT_WIDTH{1'b1}})) begin
            r_fetch_count <= r_fetch_count + FETCH_COUNT_WIDTH'(1);
        end
    end

    assign pc          = r_pc;
    assign ir          = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_valid    = r_ir_valid;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;

    localparam int IW = 40;
    localparam int PW = 5;
    localparam int DEPTH = 32;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic [PW-1:0] pc;
    logic [IW-1:0] instruction;
    logic [IW-1:0] ir;
    logic [PW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic          jump_valid = 1'b0;
    logic [PW-1:0] jump_target = '0;
    logic          restart = 1'b0;
    logic          halted;
    logic [15:0]   fetch_count;

    logic [IW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    bit do_check = 1'b1;

    int            m_pc;
    int            m_state;
    logic [IW-1:0] m_ir;
    int            m_ir_pc;
    bit            m_valid;
    int            m_count;

    assign instruction = mem[pc];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pc          (pc),
        .instruction (instruction),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .restart     (restart),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 0;
        m_state = S_IDLE;
        m_ir    = '0;
        m_ir_pc = 0;
        m_valid = 1'b0;
        m_count = 0;
    endtask

    // One clock of architectural behaviour, using the inputs currently driven
    task automatic model_step();
        bit xfer;
        bit load;
        int old_state;
        xfer      = m_valid && ir_ready;
        old_state = m_state;
        if (xfer && m_count < 65535) m_count++;
        if (jump_valid) begin
            m_pc    = int'(jump_target);
            m_valid = 1'b0;
        end else begin
            load = (old_state == S_RUN) && en && (!m_valid || ir_ready);
            if (load) begin
                m_ir    = mem[m_pc];
                m_ir_pc = m_pc;
                m_valid = 1'b1;
                m_pc    = (m_pc + 1) % DEPTH;
                if (m_ir[IW-1 -: 8] == 8'hFF) m_state = S_HALT;
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (old_state == S_IDLE && en) m_state = S_RUN;
            if (old_state == S_HALT && restart) m_state = S_RUN;
        end
    endtask

    task automatic compare_all();
        check_eq("pc", 64'(pc), 64'(m_pc));
        check_eq("ir_valid", 64'(ir_valid), 64'(m_valid));
        check_eq("ir", 64'(ir), 64'(m_ir));
        check_eq("ir_pc", 64'(ir_pc), 64'(m_ir_pc));
        check_eq("halted", 64'(halted), 64'(m_state == S_HALT));
        check_eq("fetch_count", 64'(fetch_count), 64'(m_count));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (do_check) compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_pc"}, 64'(pc), 64'd0);
        check_eq({tag, "_ir"}, 64'(ir), 64'd0);
        check_eq({tag, "_ir_pc"}, 64'(ir_pc), 64'd0);
        check_eq({tag, "_ir_valid"}, 64'(ir_valid), 64'd0);
        check_eq({tag, "_halted"}, 64'(halted), 64'd0);
        check_eq({tag, "_count"}, 64'(fetch_count), 64'd0);
    endtask

    task automatic fill_mem_plain();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {8'(8'h10 + i), $urandom};
        end
    endtask

    task automatic run_until_pc(input int target, input string tag);
        int guard;
        guard = 0;
        while (m_pc != target && guard < 64) begin
            cycle();
            guard++;
        end
        check_eq(tag, 64'(m_pc), 64'(target));
    endtask

    initial begin
        fill_mem_plain();
        model_reset();

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Stream mem[0..4] with decode always ready
        en       = 1'b1;
        ir_ready = 1'b1;
        cycle();
        check_eq("idle_no_valid", 64'(ir_valid), 64'd0);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_eq("stream_ir_pc", 64'(ir_pc), 64'(k));
            check_eq("stream_ir", 64'(ir), 64'(mem[k]));
        end
        cycle();
        check_eq("count_after_5", 64'(fetch_count), 64'd5);

        // Back-pressure: ir held, pc frozen
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("stall_ir_pc", 64'(ir_pc), 64'd5);
            check_eq("stall_pc", 64'(pc), 64'd6);
            check_eq("stall_count", 64'(fetch_count), 64'd5);
        end
        ir_ready = 1'b1;
        cycle();
        check_eq("resume_ir_pc", 64'(ir_pc), 64'd6);

        // Jump from pc 7 to 20
        run_until_pc(7, "reach_pc7");
        jump_valid  = 1'b1;
        jump_target = 5'd20;
        cycle();
        check_eq("jump_bubble", 64'(ir_valid), 64'd0);
        jump_valid = 1'b0;
        cycle();
        check_eq("jump_ir_pc", 64'(ir_pc), 64'd20);
        check_eq("jump_ir", 64'(ir), 64'(mem[20]));

        // Wrap from 31 to 0
        run_until_pc(31, "reach_pc31");
        cycle();
        check_eq("wrap_pc", 64'(pc), 64'd0);
        check_eq("wrap_last_pc", 64'(ir_pc), 64'd31);
        cycle();
        check_eq("wrap_ir_pc", 64'(ir_pc), 64'd0);

        // HALT at mem[3], then restart
        mem[3][IW-1 -: 8] = 8'hFF;
        jump_valid  = 1'b1;
        jump_target = 5'd0;
        cycle();
        jump_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        check_eq("halt_ir_pc", 64'(ir_pc), 64'd3);
        check_eq("halt_flag", 64'(halted), 64'd1);
        cycle();
        cycle();
        check_eq("halt_pc", 64'(pc), 64'd4);
        check_eq("halt_drained", 64'(ir_valid), 64'd0);
        restart = 1'b1;
        cycle();
        check_eq("restart_flag", 64'(halted), 64'd0);
        restart = 1'b0;
        cycle();
        check_eq("restart_ir_pc", 64'(ir_pc), 64'd4);
        check_eq("restart_ir", 64'(ir), 64'(mem[4]));
        mem[3][IW-1 -: 8] = 8'h13;

        // Randomised traffic with occasional HALT words, jumps and restarts
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {8'($urandom), $urandom};
            if ($urandom_range(0, 7) == 0) mem[i][IW-1 -: 8] = 8'hFF;
        end
        for (int n = 0; n < 600; n++) begin
            en          = ($urandom_range(0, 9) != 0);
            ir_ready    = ($urandom_range(0, 3) != 0);
            jump_valid  = ($urandom_range(0, 15) == 0);
            jump_target = PW'($urandom);
            restart     = ($urandom_range(0, 5) == 0);
            cycle();
        end

        // Fill ir, then reset asynchronously mid-cycle
        fill_mem_plain();
        jump_valid = 1'b0;
        en         = 1'b1;
        ir_ready   = 1'b0;
        restart    = 1'b1;
        cycle();
        restart = 1'b0;
        cycle();
        cycle();
        check_eq("pre_rst_valid", 64'(ir_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Saturate the handover counter
        en       = 1'b1;
        ir_ready = 1'b1;
        do_check = 1'b0;
        for (int n = 0; n < 65540; n++) cycle();
        do_check = 1'b1;
        check_eq("sat_count", 64'(fetch_count), 64'hFFFF);
        for (int n = 0; n < 3; n++) cycle();
        check_eq("sat_hold", 64'(fetch_count), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
